operand_mux_arbiter: RTL

//  Round-robin arbiter that shares the 8-bit 2:1 operand mux between two requesters, A and B.
//  - Drives the mux select for the winning requester each cycle.
//  - Registers the muxed byte into a single-entry output stage with a valid/ready handshake.
//  - Sits between the operand sources and the arithmetic core input.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/operand_mux_arbiter_if.sv | 27 ++
 rtl/mux2.sv | 13 +
 rtl/rr_grant2.sv | 33 +++
 rtl/operand_mux_arbiter.sv | 126 ++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the operand arbitration slice: requester source
// codes, output-stage state encoding and default widths.
package arith_pkg;

    // Requester identifiers, also used as the mux select value.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Default operand width for requesters and the output stage.
    localparam int OPERAND_W = 8;

    // Width of the optional per-requester accept counters.
    localparam int CNT_W = 8;

    // Single-entry output stage occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostage_t;

endpackage

// File: rtl/operand_mux_arbiter_if.sv
// Handshake bundle between the two operand requesters, the arbiter and
// the arithmetic core input. The slave view is the arbiter itself.
interface operand_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             mux_sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, mux_sel, out_valid, out_data, out_src
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, mux_sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux2.sv
// Generic 2:1 operand mux (sel=0 -> a, sel=1 -> b).
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins, contention goes
// to the requester that was not served last. Purely combinational.
module rr_grant2
    import arith_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       sel
);

    // Pick the winner; with no request the select parks on the last winner.
    always_comb begin
        gnt = 2'b00;
        sel = last;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                sel = SRC_A;
            end
            2'b10: begin
                gnt = 2'b10;
                sel = SRC_B;
            end
            2'b11: begin
                sel = ~last;
                gnt = (last == SRC_A) ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing the 2:1 operand mux between requesters A and B,
// feeding a single-entry registered output stage with valid/ready.
// Optional feature macro: ARB_CNT_EN adds saturating per-requester accept
// counters with a synchronous clear.
module operand_mux_arbiter
    import arith_pkg::*;
#(
    parameter int   WIDTH      = OPERAND_W,
    parameter logic START_PRIO = SRC_A
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ARB_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
`endif
    operand_mux_arbiter_if.slave bus
);

    ostage_t          state;
    ostage_t          state_nxt;
    logic             last_grant;
    logic [1:0]       gnt;
    logic             grant_sel;
    logic             pipe_ready;
    logic             accept;
    logic             out_valid;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] data_p0;
    logic             src_p0;

    rr_grant2 u_grant (
        .req  ({bus.b_valid, bus.a_valid}),
        .last (last_grant),
        .gnt  (gnt),
        .sel  (grant_sel)
    );

    mux2 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (grant_sel),
        .a   (bus.a_data),
        .b   (bus.b_data),
        .y   (mux_data)
    );

    // The stage can take a byte when empty or when its byte leaves this cycle.
    // Gating with rst makes the ready outputs drop as soon as reset asserts.
    assign pipe_ready  = (state == ST_EMPTY) | bus.out_ready;
    assign accept      = pipe_ready & (|gnt) & ~rst;
    assign bus.a_ready = accept & gnt[0];
    assign bus.b_ready = accept & gnt[1];
    assign bus.mux_sel = grant_sel;

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: an accept always fills (even while draining), a drain alone empties.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = ST_FULL;
        end else if ((state == ST_FULL) && bus.out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Output decode of the stage state.
    always_comb begin
        out_valid = 1'b0;
        if (state == ST_FULL) begin
            out_valid = 1'b1;
        end
    end

    // Capture the muxed byte and its source; remember the winner for fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0    <= '0;
            src_p0     <= SRC_A;
            last_grant <= ~START_PRIO;
        end else if (accept) begin
            data_p0    <= mux_data;
            src_p0     <= grant_sel;
            last_grant <= grant_sel;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_p0;
    assign bus.out_src   = src_p0;

`ifdef ARB_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Per-requester accept counters; the clear wins over a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (cnt_clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (bus.a_ready) begin
                cnt_a <= sat_inc(cnt_a);
            end
            if (bus.b_ready) begin
                cnt_b <= sat_inc(cnt_b);
            end
        end
    end
`endif

endmodule
